feed_scheduler: RTL and testbench

//  Sequencer for the food dispensing counter. Issues scheduled and manual feeding sessions and drives
//  the counter's enable and clear. Gates sessions on bowl-full and tank-empty, enforces a per-day

---
 rtl/feed_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_feed_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_scheduler.sv
// -----------------------------------------------------------------------------
// feed_scheduler
//   Sequencer for the food dispensing counter. Starts scheduled (interval based)
//   and manual feeding sessions, drives the dispense counter's clear/enable,
//   gates sessions on bowl-full / tank-empty, enforces a per-day session limit
//   and raises an alarm on an empty tank or a stalled dispense.
//
// Ports
//   clock         in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   tick          in   1-cycle time-base strobe (1 Hz)
//   manual_req    in   request an extra session (honoured in IDLE/COOLDOWN)
//   full_sensor   in   bowl full
//   tank_empty    in   food tank empty
//   dispense_done in   1-cycle pulse: portion complete
//   alarm_ack     in   operator acknowledge
//   day_rollover  in   1-cycle pulse: new day, clears feed count
//   disp_clear    out  1-cycle clear to dispense counter
//   disp_enable   out  enable to dispense counter
//   motor_on      out  auger drive (same as disp_enable)
//   busy          out  state != IDLE
//   alarm         out  state == ALARM
//   feeds_today   out  sessions completed since reset/rollover (saturates at 15)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a pending request that may be served
// S_CLEAR    | one cycle: clear the dispense counter, restart timeout
// S_DISPENSE | auger running until done / bowl full / empty / timeout
// S_COOLDOWN | settle time after a session, requests still latched
// S_ALARM    | tank empty or stall; waits for ack with tank refilled
// -----------------------------------------------------------------------------
module feed_scheduler #(
  parameter int FEED_INTERVAL    = 3600,
  parameter int COOLDOWN_TICKS   = 30,
  parameter int DISPENSE_TIMEOUT = 20,
  parameter int MAX_FEEDS        = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       manual_req,
  input  logic       full_sensor,
  input  logic       tank_empty,
  input  logic       dispense_done,
  input  logic       alarm_ack,
  input  logic       day_rollover,
  output logic       disp_clear,
  output logic       disp_enable,
  output logic       motor_on,
  output logic       busy,
  output logic       alarm,
  output logic [3:0] feeds_today
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DISPENSE,
    S_COOLDOWN,
    S_ALARM
  } state_t;

  localparam int IW = $clog2(FEED_INTERVAL);
  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam int TW = (DISPENSE_TIMEOUT > 1) ? $clog2(DISPENSE_TIMEOUT) : 1;

  localparam logic [IW-1:0] INT_LAST  = IW'(FEED_INTERVAL - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_TICKS - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(DISPENSE_TIMEOUT - 1);
  localparam logic [3:0]    MAX_F     = 4'(MAX_FEEDS);

  state_t        state_q, state_d;
  logic [IW-1:0] interval_cnt_q, interval_cnt_d;
  logic [CW-1:0] cooldown_cnt_q, cooldown_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          sched_pend_q, sched_pend_d;
  logic          man_pend_q, man_pend_d;
  logic [3:0]    feeds_q, feeds_d;

  logic sched_set;
  logic man_set;
  logic pend_clr;
  logic feed_inc;
  logic pending;
  logic limit_hit;

  assign pending   = sched_pend_q | man_pend_q;
  assign limit_hit = (feeds_q >= MAX_F);

  always_comb begin
    state_d        = state_q;
    interval_cnt_d = interval_cnt_q;
    cooldown_cnt_d = cooldown_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    feeds_d        = feeds_q;
    sched_set      = 1'b0;
    pend_clr       = 1'b0;
    feed_inc       = 1'b0;

    // Interval timer freezes (keeps its phase) while alarmed.
    if (tick && (state_q != S_ALARM)) begin
      if (interval_cnt_q == INT_LAST) begin
        interval_cnt_d = '0;
        sched_set      = 1'b1;
      end else begin
        interval_cnt_d = interval_cnt_q + 1'b1;
      end
    end

    man_set = manual_req && ((state_q == S_IDLE) || (state_q == S_COOLDOWN));

    case (state_q)
      S_IDLE: begin
        // An empty tank with work waiting is reported rather than silently dropped.
        if (pending && tank_empty) begin
          state_d  = S_ALARM;
          pend_clr = 1'b1;
        end else if (full_sensor || limit_hit) begin
          pend_clr = 1'b1;
        end else if (pending) begin
          state_d  = S_CLEAR;
          pend_clr = 1'b1;
        end
      end

      S_CLEAR: begin
        timeout_cnt_d = '0;
        state_d       = S_DISPENSE;
      end

      S_DISPENSE: begin
        if (dispense_done || full_sensor) begin
          state_d  = S_COOLDOWN;
          feed_inc = 1'b1;
        end else if (tank_empty) begin
          state_d  = S_ALARM;
          pend_clr = 1'b1;
        end else if (tick) begin
          if (timeout_cnt_q == TOUT_LAST) begin
            state_d  = S_ALARM;
            pend_clr = 1'b1;
          end else begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
          end
        end
      end

      S_COOLDOWN: begin
        if (tick) begin
          if (cooldown_cnt_q == COOL_LAST) begin
            cooldown_cnt_d = '0;
            state_d        = S_IDLE;
          end else begin
            cooldown_cnt_d = cooldown_cnt_q + 1'b1;
          end
        end
      end

      S_ALARM: begin
        if (alarm_ack && !tank_empty) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clearing wins over a same-cycle set so a held request yields one session.
    sched_pend_d = pend_clr ? 1'b0 : (sched_pend_q | sched_set);
    man_pend_d   = pend_clr ? 1'b0 : (man_pend_q | man_set);

    if (day_rollover) begin
      feeds_d = feed_inc ? 4'd1 : 4'd0;
    end else if (feed_inc && (feeds_q != 4'hF)) begin
      feeds_d = feeds_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      interval_cnt_q <= '0;
      cooldown_cnt_q <= '0;
      timeout_cnt_q  <= '0;
      sched_pend_q   <= 1'b0;
      man_pend_q     <= 1'b0;
      feeds_q        <= 4'd0;
    end else begin
      state_q        <= state_d;
      interval_cnt_q <= interval_cnt_d;
      cooldown_cnt_q <= cooldown_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      sched_pend_q   <= sched_pend_d;
      man_pend_q     <= man_pend_d;
      feeds_q        <= feeds_d;
    end
  end

  assign disp_clear  = (state_q == S_CLEAR);
  assign disp_enable = (state_q == S_DISPENSE);
  assign motor_on    = (state_q == S_DISPENSE);
  assign busy        = (state_q != S_IDLE);
  assign alarm       = (state_q == S_ALARM);
  assign feeds_today = feeds_q;

endmodule

// File: tb/tb_feed_scheduler.sv
module tb_feed_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, manual_req = 1'b0, full_sensor = 1'b0, tank_empty = 1'b0;
  logic dispense_done = 1'b0, alarm_ack = 1'b0, day_rollover = 1'b0;
  logic disp_clear, disp_enable, motor_on, busy, alarm;
  logic [3:0] feeds_today;

  int n_cmp = 0;
  int n_bad = 0;
  int model_feeds = 0;
  int exp_q[$];

  feed_scheduler #(
    .FEED_INTERVAL(4), .COOLDOWN_TICKS(2), .DISPENSE_TIMEOUT(3), .MAX_FEEDS(2)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .manual_req(manual_req),
    .full_sensor(full_sensor), .tank_empty(tank_empty), .dispense_done(dispense_done),
    .alarm_ack(alarm_ack), .day_rollover(day_rollover), .disp_clear(disp_clear),
    .disp_enable(disp_enable), .motor_on(motor_on), .busy(busy), .alarm(alarm),
    .feeds_today(feeds_today)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic manual_pulse();
    manual_req = 1'b1; step(); manual_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    model_feeds = 0;
    exp_q.delete();
  endtask

  // Scoreboard: push the feed count a session should leave behind.
  task automatic expect_session();
    model_feeds = (model_feeds >= 15) ? 15 : model_feeds + 1;
    exp_q.push_back(model_feeds);
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic wait_clear(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (disp_clear === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic quiet(input int n, output bit saw);
    saw = 1'b0;
    repeat (n) begin
      step();
      if (disp_clear === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
  endtask

  // Waits for disp_clear, lets DISPENSE run done_dly cycles, then pulses done
  // (optionally together with day_rollover). Returns observations only.
  task automatic run_session(input int done_dly, input bit roll, output bit found,
                             output int clr_len, output int en_len, output bit en_after);
    clr_len = 0; en_len = 0; en_after = 1'b1;
    wait_clear(found);
    if (!found) return;
    while (disp_clear === 1'b1 && clr_len < 4) begin
      clr_len++;
      step();
    end
    repeat (done_dly - 1) begin
      if (disp_enable === 1'b1 && motor_on === 1'b1) en_len++;
      step();
    end
    if (disp_enable === 1'b1 && motor_on === 1'b1) en_len++;
    dispense_done = 1'b1; day_rollover = roll;
    step();
    dispense_done = 1'b0; day_rollover = 1'b0;
    en_after = disp_enable;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (disp_clear !== 1'b0) begin n_bad++; $display("FAIL rst_disp_clear: got %b want 0", disp_clear); end
    n_cmp++; if (disp_enable !== 1'b0) begin n_bad++; $display("FAIL rst_disp_enable: got %b want 0", disp_enable); end
    n_cmp++; if (motor_on !== 1'b0) begin n_bad++; $display("FAIL rst_motor_on: got %b want 0", motor_on); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL rst_alarm: got %b want 0", alarm); end
    n_cmp++; if (feeds_today !== 4'd0) begin n_bad++; $display("FAIL rst_feeds: got %0d want 0", feeds_today); end
  endtask

  task automatic test_scheduled();
    bit found, ena, saw; int clr, en, e;
    do_reset();
    repeat (3) tick_pulse();
    quiet(3, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL sched_no_early: got %b want 0", saw); end
    tick_pulse();
    expect_session();
    run_session(5, 1'b0, found, clr, en, ena);
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL sched_clear_seen: got %b want 1", found); end
    n_cmp++; if (clr != 1) begin n_bad++; $display("FAIL sched_clear_len: got %0d want 1", clr); end
    n_cmp++; if (en != 5) begin n_bad++; $display("FAIL sched_enable_len: got %0d want 5", en); end
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL sched_enable_drop: got %b want 0", ena); end
    e = pop_exp();
    n_cmp++; if (e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL sched_feeds: got %0d want %0d", feeds_today, e); end
    tick_pulse();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sched_cooldown_busy: got %b want 1", busy); end
    tick_pulse();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sched_back_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_manual();
    bit found, ena, saw; int clr, en, e;
    do_reset();
    manual_pulse();
    expect_session();
    run_session(3, 1'b0, found, clr, en, ena);
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL man_clear_seen: got %b want 1", found); end
    n_cmp++; if (en != 3) begin n_bad++; $display("FAIL man_enable_len: got %0d want 3", en); end
    e = pop_exp();
    n_cmp++; if (e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL man_feeds1: got %0d want %0d", feeds_today, e); end
    // request during COOLDOWN is held and served on return to IDLE
    manual_pulse();
    expect_session();
    tick_pulse(); tick_pulse();
    run_session(2, 1'b0, found, clr, en, ena);
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL man_cooldown_req: got %b want 1", found); end
    e = pop_exp();
    n_cmp++; if (e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL man_feeds2: got %0d want %0d", feeds_today, e); end
    tick_pulse(); tick_pulse();
    day_rollover = 1'b1; step(); day_rollover = 1'b0;
    model_feeds = 0;
    n_cmp++; if (feeds_today !== 4'd0) begin n_bad++; $display("FAIL man_rollover: got %0d want 0", feeds_today); end
    full_sensor = 1'b1;
    manual_pulse();
    quiet(4, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL man_full_blocks: got %b want 0", saw); end
    full_sensor = 1'b0;
    quiet(4, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL man_full_dropped: got %b want 0", saw); end
  endtask

  task automatic test_limit();
    bit found, ena, saw; int clr, en, e;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      manual_pulse();
      expect_session();
      run_session(2, 1'b0, found, clr, en, ena);
      e = pop_exp();
      n_cmp++; if (!found || e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL lim_session%0d: found=%b got %0d want %0d", s, found, feeds_today, e); end
      tick_pulse(); tick_pulse();
    end
    repeat (4) tick_pulse();
    manual_pulse();
    quiet(5, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL lim_blocked: got %b want 0", saw); end
    n_cmp++; if (feeds_today !== 4'(model_feeds)) begin n_bad++; $display("FAIL lim_feeds_hold: got %0d want %0d", feeds_today, model_feeds); end
    day_rollover = 1'b1; step(); day_rollover = 1'b0;
    model_feeds = 0;
    n_cmp++; if (feeds_today !== 4'd0) begin n_bad++; $display("FAIL lim_rollover: got %0d want 0", feeds_today); end
    manual_pulse();
    expect_session();
    run_session(2, 1'b0, found, clr, en, ena);
    e = pop_exp();
    n_cmp++; if (!found || e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL lim_after_roll: found=%b got %0d want %0d", found, feeds_today, e); end
  endtask

  task automatic test_alarm_tank();
    bit found, saw;
    do_reset();
    manual_pulse();
    wait_clear(found);
    step(); step();
    tank_empty = 1'b1;
    step();
    n_cmp++; if (alarm !== 1'b1 || motor_on !== 1'b0) begin n_bad++; $display("FAIL tank_alarm: alarm=%b motor=%b want 1/0", alarm, motor_on); end
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL tank_ack_ignored: alarm=%b want 1", alarm); end
    tank_empty = 1'b0;
    step();
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL tank_needs_ack: alarm=%b want 1", alarm); end
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    n_cmp++; if (alarm !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL tank_ack_idle: alarm=%b busy=%b want 0/0", alarm, busy); end
    n_cmp++; if (feeds_today !== 4'd0) begin n_bad++; $display("FAIL tank_no_count: got %0d want 0", feeds_today); end
    quiet(4, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL tank_no_restart: got %b want 0", saw); end
  endtask

  task automatic test_timeout();
    bit found; int e;
    do_reset();
    manual_pulse();
    wait_clear(found);
    step();
    tick_pulse(); tick_pulse();
    n_cmp++; if (motor_on !== 1'b1 || alarm !== 1'b0) begin n_bad++; $display("FAIL tout_before: motor=%b alarm=%b want 1/0", motor_on, alarm); end
    tick_pulse();
    n_cmp++; if (alarm !== 1'b1 || motor_on !== 1'b0) begin n_bad++; $display("FAIL tout_alarm: alarm=%b motor=%b want 1/0", alarm, motor_on); end
    n_cmp++; if (feeds_today !== 4'(model_feeds)) begin n_bad++; $display("FAIL tout_no_count: got %0d want %0d", feeds_today, model_feeds); end
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    manual_pulse();
    expect_session();
    wait_clear(found);
    step();
    dispense_done = 1'b1; tank_empty = 1'b1;
    step();
    dispense_done = 1'b0; tank_empty = 1'b0;
    e = pop_exp();
    n_cmp++; if (alarm !== 1'b0 || busy !== 1'b1 || motor_on !== 1'b0) begin n_bad++; $display("FAIL done_beats_tank: alarm=%b busy=%b motor=%b want 0/1/0", alarm, busy, motor_on); end
    n_cmp++; if (e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL done_beats_tank_feeds: got %0d want %0d", feeds_today, e); end
  endtask

  task automatic test_back_to_back();
    bit found, ena, saw; int clr, en, e;
    do_reset();
    repeat (3) tick_pulse();
    tick = 1'b1; manual_req = 1'b1; step(); tick = 1'b0; manual_req = 1'b0;
    expect_session();
    run_session(2, 1'b0, found, clr, en, ena);
    e = pop_exp();
    n_cmp++; if (!found || e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL b2b_first: found=%b got %0d want %0d", found, feeds_today, e); end
    tick_pulse(); tick_pulse();
    quiet(6, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL b2b_single_session: got %b want 0", saw); end
    manual_pulse();
    model_feeds = 1;
    exp_q.push_back(model_feeds);
    run_session(2, 1'b1, found, clr, en, ena);
    e = pop_exp();
    n_cmp++; if (!found || e < 0 || feeds_today !== 4'(e)) begin n_bad++; $display("FAIL b2b_roll_and_inc: found=%b got %0d want %0d", found, feeds_today, e); end
  endtask

  task automatic test_reset_mid();
    bit found, saw;
    do_reset();
    manual_pulse();
    wait_clear(found);
    step();
    tick_pulse(); tick_pulse();
    n_cmp++; if (motor_on !== 1'b1) begin n_bad++; $display("FAIL rmid_running: motor=%b want 1", motor_on); end
    reset = 1'b1; step();
    n_cmp++; if ({disp_clear, disp_enable, motor_on, busy, alarm} !== 5'b0 || feeds_today !== 4'd0) begin
      n_bad++; $display("FAIL rmid_outputs: got %b feeds=%0d want 00000 feeds=0", {disp_clear, disp_enable, motor_on, busy, alarm}, feeds_today);
    end
    reset = 1'b0;
    model_feeds = 0;
    repeat (3) tick_pulse();
    quiet(3, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rmid_interval_restart: got %b want 0", saw); end
    tick_pulse();
    wait_clear(found);
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rmid_sched_after_4: got %b want 1", found); end
  endtask

  initial begin
    test_reset();
    test_scheduled();
    test_manual();
    test_limit();
    test_alarm_tank();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
